strobe_monitor: RTL and testbench

STROBE_MONITOR -- requirements
Module: strobe_monitor

---
 rtl/strobe_monitor.sv | 152 +++++++++++++++
 tb/tb_strobe_monitor.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/strobe_monitor.sv
// Strobe interval monitor: learns a repeating strobe period, locks onto it,
// and flags early or missing strobes with a saturating error count.
module strobe_monitor #(
    parameter int MAX_PERIOD = 64,
    parameter int LOCK_COUNT = 4,
    localparam int BW = $clog2(MAX_PERIOD + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          enable_i,
    input  logic          strobe_i,
    output logic [BW-1:0] period_o,
    output logic          locked_o,
    output logic          early_o,
    output logic          missing_o,
    output logic [7:0]    err_count_o
);

    localparam int MW = $clog2(LOCK_COUNT + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    localparam logic [BW-1:0] MAX_CNT    = BW'(MAX_PERIOD);
    localparam logic [BW-1:0] CNT_ONE    = BW'(1);
    localparam logic [MW-1:0] LOCK_MATCH = MW'(LOCK_COUNT);
    localparam logic [MW-1:0] MATCH_ONE  = MW'(1);

    logic [1:0]    state, state_n;
    logic [BW-1:0] cnt, cnt_n;
    logic [BW-1:0] cand, cand_n;
    logic [MW-1:0] match, match_n, match_new;
    logic [BW-1:0] period_n;
    logic          locked_n;
    logic          early_n;
    logic          missing_n;
    logic [7:0]    err_n;

    function automatic logic [BW-1:0] cnt_step(input logic [BW-1:0] c);
        return (c == MAX_CNT) ? c : c + CNT_ONE;
    endfunction

    function automatic logic [7:0] err_step(input logic [7:0] e);
        return (e == 8'hFF) ? e : e + 8'd1;
    endfunction

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        cand_n    = cand;
        match_n   = match;
        match_new = match;
        period_n  = period_o;
        locked_n  = locked_o;
        early_n   = 1'b0;
        missing_n = 1'b0;
        err_n     = err_count_o;

        // Everything except the flag pulses holds while disabled.
        if (enable_i) begin
            case (state)
                ST_IDLE: begin
                    cnt_n = '0;
                    if (strobe_i) begin
                        state_n = ST_ACQUIRE;
                        cand_n  = '0;
                        match_n = '0;
                        cnt_n   = CNT_ONE;
                    end
                end

                ST_ACQUIRE: begin
                    if (strobe_i) begin
                        cnt_n = CNT_ONE;
                        if (cnt == cand) begin
                            match_new = match + MATCH_ONE;
                        end else begin
                            cand_n    = cnt;
                            match_new = MATCH_ONE;
                        end
                        match_n = match_new;
                        if (match_new == LOCK_MATCH) begin
                            state_n  = ST_LOCKED;
                            period_n = cnt;
                            locked_n = 1'b1;
                        end
                    end else if (cnt == MAX_CNT) begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_step(cnt);
                    end
                end

                ST_LOCKED: begin
                    // A strobe landing on the expected cycle wins over the missing check.
                    if (strobe_i) begin
                        cnt_n = CNT_ONE;
                        if (cnt != period_o) begin
                            early_n  = 1'b1;
                            err_n    = err_step(err_count_o);
                            state_n  = ST_ACQUIRE;
                            cand_n   = cnt;
                            match_n  = MATCH_ONE;
                            locked_n = 1'b0;
                        end
                    end else if (cnt == period_o) begin
                        missing_n = 1'b1;
                        err_n     = err_step(err_count_o);
                        state_n   = ST_IDLE;
                        cnt_n     = '0;
                        locked_n  = 1'b0;
                    end else begin
                        cnt_n = cnt_step(cnt);
                    end
                end

                default: begin
                    state_n  = ST_IDLE;
                    cnt_n    = '0;
                    locked_n = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            cand        <= '0;
            match       <= '0;
            period_o    <= '0;
            locked_o    <= 1'b0;
            early_o     <= 1'b0;
            missing_o   <= 1'b0;
            err_count_o <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            cand        <= cand_n;
            match       <= match_n;
            period_o    <= period_n;
            locked_o    <= locked_n;
            early_o     <= early_n;
            missing_o   <= missing_n;
            err_count_o <= err_n;
        end
    end

endmodule

// File: tb/tb_strobe_monitor.sv
// Directed bench for strobe_monitor: a reference model queues the expected
// outputs for every cycle, plus spot checks on the headline scenarios.
module tb_strobe_monitor;

    localparam int MAXP = 64;
    localparam int LC   = 4;
    localparam int BW   = $clog2(MAXP + 1);

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          enable_i = 1'b1;
    logic          strobe_i = 1'b0;
    logic [BW-1:0] period_o;
    logic          locked_o;
    logic          early_o;
    logic          missing_o;
    logic [7:0]    err_count_o;

    strobe_monitor #(.MAX_PERIOD(MAXP), .LOCK_COUNT(LC)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .strobe_i(strobe_i),
        .period_o(period_o), .locked_o(locked_o), .early_o(early_o),
        .missing_o(missing_o), .err_count_o(err_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [BW-1:0] period;
        logic          locked;
        logic          early;
        logic          missing;
        logic [7:0]    err;
    } obs_t;

    obs_t  exp_q[$];
    int    tests = 0;
    int    fails = 0;
    string phase = "reset";

    // Reference model state (0 idle, 1 acquire, 2 locked)
    int m_state = 0, m_cnt = 0, m_cand = 0, m_match = 0, m_per = 0, m_err = 0;
    bit m_lock = 0, m_early = 0, m_miss = 0;

    task automatic model_step(input logic r, input logic e, input logic s);
        if (!r) begin
            m_state = 0; m_cnt = 0; m_cand = 0; m_match = 0; m_per = 0; m_err = 0;
            m_lock = 0; m_early = 0; m_miss = 0;
            return;
        end
        m_early = 0;
        m_miss  = 0;
        if (!e) return;
        case (m_state)
            0: begin
                if (s) begin m_state = 1; m_cand = 0; m_match = 0; m_cnt = 1; end
                else m_cnt = 0;
            end
            1: begin
                if (s) begin
                    if (m_cnt == m_cand) m_match++;
                    else begin m_cand = m_cnt; m_match = 1; end
                    if (m_match == LC) begin m_state = 2; m_per = m_cand; m_lock = 1; end
                    m_cnt = 1;
                end else if (m_cnt == MAXP) begin
                    m_state = 0; m_cnt = 0;
                end else m_cnt++;
            end
            default: begin
                if (s) begin
                    if (m_cnt < m_per) begin
                        m_early = 1; if (m_err < 255) m_err++;
                        m_state = 1; m_cand = m_cnt; m_match = 1; m_lock = 0;
                    end
                    m_cnt = 1;
                end else if (m_cnt == m_per) begin
                    m_miss = 1; if (m_err < 255) m_err++;
                    m_state = 0; m_cnt = 0; m_lock = 0;
                end else if (m_cnt < MAXP) m_cnt++;
            end
        endcase
    endtask

    task automatic cyc(input logic r, input logic e, input logic s);
        obs_t got, exp;
        rst_i = r; enable_i = e; strobe_i = s;
        model_step(r, e, s);
        exp_q.push_back({BW'(m_per), m_lock, m_early, m_miss, 8'(m_err)});
        @(posedge clk_i);
        #1;
        got = {period_o, locked_o, early_o, missing_o, err_count_o};
        exp = exp_q.pop_front();
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL cycle[%s] observed=%h expected=%h", phase, got, exp);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0);
    endtask

    task automatic stb();
        cyc(1'b1, 1'b1, 1'b1);
    endtask

    // Strobe arriving n cycles after the previous one.
    task automatic gap(input int n);
        run(n - 1);
        stb();
    endtask

    initial begin
        phase = "reset";
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        check("reset_locked", 32'(locked_o), 0);
        check("reset_period", 32'(period_o), 0);
        check("reset_err", 32'(err_count_o), 0);
        run(3);

        phase = "lock10";
        stb();
        for (int i = 0; i < 3; i++) gap(10);
        run(9);
        check("lock_not_yet", 32'(locked_o), 0);
        stb();
        check("lock_locked", 32'(locked_o), 1);
        check("lock_period", 32'(period_o), 10);
        check("lock_noflag", 32'({early_o, missing_o}), 0);

        phase = "ontime";
        gap(10);
        gap(10);
        check("ontime_locked", 32'(locked_o), 1);

        phase = "early";
        gap(7);
        check("early_pulse", 32'(early_o), 1);
        check("early_unlock", 32'(locked_o), 0);
        check("early_err", 32'(err_count_o), 1);
        for (int i = 0; i < 3; i++) gap(7);
        check("relock_locked", 32'(locked_o), 1);
        check("relock_period", 32'(period_o), 7);

        phase = "missing7";
        run(6);
        check("miss7_quiet", 32'(missing_o), 0);
        run(1);
        check("miss7_pulse", 32'(missing_o), 1);
        check("miss7_period_held", 32'(period_o), 7);

        phase = "missing10";
        stb();
        for (int i = 0; i < 4; i++) gap(10);
        check("relock10", 32'(period_o), 10);
        run(9);
        check("miss10_quiet", 32'(missing_o), 0);
        run(1);
        check("miss10_pulse", 32'(missing_o), 1);
        check("miss10_err", 32'(err_count_o), 3);
        check("miss10_unlock", 32'(locked_o), 0);
        run(2);

        phase = "timeout";
        stb();
        run(70);
        check("timeout_err", 32'(err_count_o), 3);
        check("timeout_flags", 32'({early_o, missing_o}), 0);
        stb();
        for (int i = 0; i < 3; i++) gap(10);
        check("timeout_idle_restart", 32'(locked_o), 0);
        gap(10);
        check("timeout_relock", 32'(locked_o), 1);

        phase = "freeze";
        run(4);
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, (i == 10) ? 1'b1 : 1'b0);
        check("freeze_locked", 32'(locked_o), 1);
        run(5);
        stb();
        check("freeze_locked_after", 32'(locked_o), 1);
        check("freeze_err", 32'(err_count_o), 3);

        phase = "midreset";
        gap(5);
        cyc(1'b0, 1'b1, 1'b1);
        check("midreset_outs", 32'({period_o, locked_o, early_o, missing_o, err_count_o}), 0);

        phase = "saturate";
        stb();
        for (int i = 0; i < 4; i++) gap(2);
        for (int k = 0; k < 256; k++) begin
            gap(1);
            for (int i = 0; i < 4; i++) gap(2);
        end
        check("sat_err", 32'(err_count_o), 255);
        gap(1);
        check("sat_early_still", 32'(early_o), 1);
        check("sat_err_hold", 32'(err_count_o), 255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
